// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive engine and its bit sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP_0,
        STOP_1
    } rx_state_t;

    localparam int MIN_DATA_BITS = 5;

    // Out-of-range character widths snap to the nearest supported width.
    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
        if (req < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end
        if (int'(req) > max_bits) begin
            return 4'(max_bits);
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Serial input synchroniser, tick-qualified falling-edge detect and the
// oversampling tick counter that marks mid-bit and full-bit points.
module uart_rx_bit_sampler #(
    parameter int OVS = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic baud_tick,
    input  logic rxd,
    input  logic cnt_clr,
    output logic rxd_s,
    output logic fall_edge,
    output logic mid_strobe,
    output logic full_strobe
);

    localparam int CNT_W = $clog2(OVS);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] tick_cnt_reg;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            prev_reg     <= 1'b1;
            tick_cnt_reg <= '0;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            if (baud_tick) begin
                prev_reg <= sync2_reg;
            end
            if (cnt_clr) begin
                tick_cnt_reg <= '0;
            end else if (baud_tick) begin
                tick_cnt_reg <= (tick_cnt_reg == CNT_W'(OVS - 1)) ? '0 : tick_cnt_reg + 1'b1;
            end
        end
    end

    assign rxd_s       = sync2_reg;
    assign fall_edge   = baud_tick & prev_reg & ~sync2_reg;
    assign mid_strobe  = baud_tick & (tick_cnt_reg == CNT_W'(OVS / 2 - 1));
    assign full_strobe = baud_tick & (tick_cnt_reg == CNT_W'(OVS - 1));

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: start detect, variable-width data, optional
// parity, 1/2 stop bits, valid/ready hand-off with error and timeout pulses.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX   = 8,
    parameter int OVS          = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  baud_tick,
    input  logic                  RXen,
    input  logic                  rxd,
    input  logic [3:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_stop2,
    output logic [DATA_W_MAX-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  timeout_flag,
    output logic                  busy
);

    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);

    rx_state_t state_reg, state_next;

    logic rxd_s, fall_edge, mid_strobe, full_strobe, cnt_clr;
    logic start_det, start_ok, sample_bit, par_check, stop_check, complete;
    logic load, overrun, to_clr;

    logic [3:0]            bit_cnt_reg;
    logic [3:0]            nbits_reg;
    logic                  par_en_reg, par_odd_reg, stop2_reg;
    logic                  par_err_reg, frm_err_reg;
    logic [DATA_W_MAX-1:0] shift_reg, shift_next;
    logic [DATA_W_MAX-1:0] rx_data_reg;
    logic                  rx_valid_reg, rx_done_reg, parity_err_reg, frame_err_reg;
    logic                  overrun_err_reg, timeout_flag_reg;
    logic [TO_W-1:0]       timeout_cnt_reg;

    uart_rx_bit_sampler #(.OVS(OVS)) u_sampler (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .cnt_clr     (cnt_clr),
        .rxd_s       (rxd_s),
        .fall_edge   (fall_edge),
        .mid_strobe  (mid_strobe),
        .full_strobe (full_strobe)
    );

    always_comb begin
        state_next = state_reg;
        start_det  = 1'b0;
        start_ok   = 1'b0;
        sample_bit = 1'b0;
        par_check  = 1'b0;
        stop_check = 1'b0;
        complete   = 1'b0;
        if (!RXen) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fall_edge) begin
                        state_next = START;
                        start_det  = 1'b1;
                    end
                end
                START: begin
                    if (mid_strobe) begin
                        if (rxd_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            start_ok   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (full_strobe) begin
                        sample_bit = 1'b1;
                        if (bit_cnt_reg == nbits_reg - 4'd1) begin
                            state_next = par_en_reg ? PARITY : STOP_0;
                        end
                    end
                end
                PARITY: begin
                    if (full_strobe) begin
                        par_check  = 1'b1;
                        state_next = STOP_0;
                    end
                end
                STOP_0: begin
                    if (full_strobe) begin
                        stop_check = 1'b1;
                        if (stop2_reg) begin
                            state_next = STOP_1;
                        end else begin
                            state_next = IDLE;
                            complete   = 1'b1;
                        end
                    end
                end
                STOP_1: begin
                    if (full_strobe) begin
                        state_next = IDLE;
                        complete   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Re-centre the tick counter on the start edge and again at mid-start,
    // so every later full-bit strobe lands in the middle of a bit.
    assign cnt_clr = ~RXen | start_det | start_ok;

    generate
        for (genvar gi = 0; gi < DATA_W_MAX; gi++) begin : g_shift
            assign shift_next[gi] = (sample_bit && bit_cnt_reg == 4'(gi)) ? rxd_s : shift_reg[gi];
        end
    endgenerate

    assign load    = complete & (~rx_valid_reg | rx_ready);
    assign overrun = complete & ~load;
    assign to_clr  = start_det | ~rx_valid_reg;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            nbits_reg        <= '0;
            par_en_reg       <= 1'b0;
            par_odd_reg      <= 1'b0;
            stop2_reg        <= 1'b0;
            par_err_reg      <= 1'b0;
            frm_err_reg      <= 1'b0;
            shift_reg        <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rx_done_reg      <= 1'b0;
            parity_err_reg   <= 1'b0;
            frame_err_reg    <= 1'b0;
            overrun_err_reg  <= 1'b0;
            timeout_flag_reg <= 1'b0;
            timeout_cnt_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            rx_done_reg     <= complete;
            parity_err_reg  <= complete & par_err_reg;
            frame_err_reg   <= complete & (frm_err_reg | ~rxd_s);
            overrun_err_reg <= overrun;

            if (start_det) begin
                nbits_reg   <= clamp_bits(cfg_data_bits, DATA_W_MAX);
                par_en_reg  <= cfg_parity_en;
                par_odd_reg <= cfg_parity_odd;
                stop2_reg   <= cfg_stop2;
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
                par_err_reg <= 1'b0;
                frm_err_reg <= 1'b0;
            end
            if (sample_bit) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            if (par_check) begin
                par_err_reg <= rxd_s ^ (^shift_reg) ^ par_odd_reg;
            end
            if (stop_check && !rxd_s) begin
                frm_err_reg <= 1'b1;
            end

            if (load) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            // Idle bit-time counter saturates so the flag fires once per unread character.
            timeout_flag_reg <= 1'b0;
            if (to_clr) begin
                timeout_cnt_reg <= '0;
            end else if (state_reg == IDLE && full_strobe &&
                         timeout_cnt_reg != TO_W'(TIMEOUT_BITS)) begin
                timeout_cnt_reg  <= timeout_cnt_reg + 1'b1;
                timeout_flag_reg <= (timeout_cnt_reg == TO_W'(TIMEOUT_BITS - 1));
            end
        end
    end

    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign rx_done      = rx_done_reg;
    assign parity_err   = parity_err_reg;
    assign frame_err    = frame_err_reg;
    assign overrun_err  = overrun_err_reg;
    assign timeout_flag = timeout_flag_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed and randomised frames against a frame-level reference model.
module tb_uart_rx_engine;

    localparam int DW  = 8;
    localparam int OVS = 16;
    localparam int TOB = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          baud_tick;
    logic          RXen;
    logic          rxd;
    logic [3:0]    cfg_data_bits;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic          cfg_stop2;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_done;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;
    logic          timeout_flag;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    int done_cnt = 0, perr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, to_cnt = 0, stray_cnt = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_perr = 1'b0;
    logic          last_ferr = 1'b0;

    // reference model of the receive buffer
    logic [DW-1:0] model_data  = '0;
    logic          model_valid = 1'b0;
    int            model_ovr   = 0;

    always #5 PCLK = ~PCLK;

    uart_rx_engine #(.DATA_W_MAX(DW), .OVS(OVS), .TIMEOUT_BITS(TOB)) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .baud_tick      (baud_tick),
        .RXen           (RXen),
        .rxd            (rxd),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_done        (rx_done),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err),
        .timeout_flag   (timeout_flag),
        .busy           (busy)
    );

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge PCLK);
            baud_tick = 1'b1;
            @(negedge PCLK);
            baud_tick = 1'b0;
        end
    end

    always @(negedge PCLK) begin
        if (rx_done) begin
            done_cnt  <= done_cnt + 1;
            last_data <= rx_data;
            last_perr <= parity_err;
            last_ferr <= frame_err;
            if (parity_err) perr_cnt <= perr_cnt + 1;
            if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        end
        if ((parity_err || frame_err) && !rx_done) stray_cnt <= stray_cnt + 1;
        if (overrun_err)  ovr_cnt <= ovr_cnt + 1;
        if (timeout_flag) to_cnt  <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] width_mask(input int nb);
        return DW'((1 << nb) - 1);
    endfunction

    function automatic int eff_bits(input logic [3:0] c);
        if (c < 4'd5) return 5;
        if (c > 4'(DW)) return DW;
        return int'(c);
    endfunction

    task automatic model_complete(input logic [DW-1:0] v);
        if (!model_valid || rx_ready) begin
            model_data  = v;
            model_valid = !rx_ready;
        end else begin
            model_ovr++;
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge PCLK);
            while (baud_tick !== 1'b1) @(posedge PCLK);
        end
    endtask

    task automatic idle_bits(input int n);
        @(negedge PCLK);
        rxd = 1'b1;
        wait_ticks(n * OVS);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int nb, input bit flip, input bit stop_val);
        bit            bits[$];
        logic [DW-1:0] m;
        m = d & width_mask(nb);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(m[i]);
        if (cfg_parity_en) bits.push_back((^m) ^ cfg_parity_odd ^ flip);
        bits.push_back(stop_val);
        if (cfg_stop2) bits.push_back(stop_val);
        foreach (bits[i]) begin
            @(negedge PCLK);
            rxd = bits[i];
            wait_ticks(OVS);
        end
    endtask

    task automatic wait_done(input int base, input string tag);
        int k = 0;
        while (done_cnt == base && k < 20 * OVS * 4) begin
            @(negedge PCLK);
            k++;
        end
        @(negedge PCLK);
        check({tag, "_done"}, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] expd;
        int            nb, b_done, b_perr, b_ferr, b_ovr, b_to, b_mo;
        bit            flip;

        PRESETn = 1'b0; RXen = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        repeat (5) @(negedge PCLK);
        check("reset_outs", 32'({rx_data, rx_valid, rx_done, parity_err, frame_err,
                                 overrun_err, timeout_flag, busy}), 32'd0);
        PRESETn = 1'b1;
        idle_bits(2);

        // 8N1 0xA5, held unread then accepted
        b_done = done_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b1);
        model_complete(8'hA5);
        wait_done(b_done, "a5");
        check("a5_data", 32'(last_data), 32'(model_data));
        check("a5_valid", 32'(rx_valid), 32'(model_valid));
        check("a5_errs", 32'({last_perr, last_ferr}), 32'd0);
        @(negedge PCLK);
        rx_ready = 1'b1;
        @(negedge PCLK);
        model_valid = 1'b0;
        check("a5_consumed", 32'(rx_valid), 32'(model_valid));

        // 7E2 0x35 with good and flipped parity
        cfg_data_bits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        for (int p = 0; p < 2; p++) begin
            idle_bits(1);
            b_done = done_cnt;
            send_frame(8'h35, 7, p[0], 1'b1);
            model_complete(8'h35);
            wait_done(b_done, "p35");
            check($sformatf("p35_%0d_data", p), 32'(last_data), 32'(model_data));
            check($sformatf("p35_%0d_perr", p), 32'(last_perr), 32'(p));
            check($sformatf("p35_%0d_ferr", p), 32'(last_ferr), 32'd0);
        end

        // randomised character formats
        b_ovr = ovr_cnt;
        for (int t = 0; t < 8; t++) begin
            cfg_data_bits  = 4'($urandom_range(0, 15));
            cfg_parity_en  = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            cfg_stop2      = 1'($urandom_range(0, 1));
            flip           = 1'($urandom_range(0, 1));
            d              = DW'($urandom);
            nb             = eff_bits(cfg_data_bits);
            expd           = d & width_mask(nb);
            idle_bits($urandom_range(1, 2));
            b_done = done_cnt;
            send_frame(d, nb, flip, 1'b1);
            model_complete(expd);
            wait_done(b_done, $sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_data", t), 32'(last_data), 32'(model_data));
            check($sformatf("rnd%0d_perr", t), 32'(last_perr), 32'(cfg_parity_en & flip));
            check($sformatf("rnd%0d_ferr", t), 32'(last_ferr), 32'd0);
        end
        check("rnd_no_ovr", 32'(ovr_cnt - b_ovr), 32'd0);

        // short low glitch is a false start
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        idle_bits(2);
        b_done = done_cnt;
        @(negedge PCLK);
        rxd = 1'b0;
        wait_ticks(4);
        @(negedge PCLK);
        check("glitch_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        wait_ticks(OVS / 2 + 2);
        @(negedge PCLK);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_nodone", 32'(done_cnt - b_done), 32'd0);

        // break: bad stop bit, then line held low for three characters
        idle_bits(2);
        b_done = done_cnt; b_ferr = ferr_cnt;
        send_frame(8'h00, 8, 1'b0, 1'b0);
        model_complete(8'h00);
        wait_done(b_done, "brk");
        wait_ticks(30 * OVS);
        @(negedge PCLK);
        check("brk_ferr", 32'(ferr_cnt - b_ferr), 32'd1);
        check("brk_dones", 32'(done_cnt - b_done), 32'd1);
        check("brk_busy", 32'(busy), 32'd0);
        idle_bits(2);
        b_done = done_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b1);
        model_complete(8'h11);
        wait_done(b_done, "post_brk");
        check("post_brk_data", 32'(last_data), 32'(model_data));
        check("post_brk_ferr", 32'(ferr_cnt - b_ferr), 32'd1);

        // overrun with the buffer stalled, then idle timeout
        idle_bits(1);
        @(negedge PCLK);
        rx_ready = 1'b0;
        b_ovr = ovr_cnt; b_mo = model_ovr; b_to = to_cnt;
        b_done = done_cnt;
        send_frame(8'h01, 8, 1'b0, 1'b1);
        model_complete(8'h01);
        wait_done(b_done, "ovr1");
        check("ovr1_valid", 32'(rx_valid), 32'(model_valid));
        idle_bits(1);
        b_done = done_cnt;
        send_frame(8'h02, 8, 1'b0, 1'b1);
        model_complete(8'h02);
        wait_done(b_done, "ovr2");
        check("ovr2_count", 32'(ovr_cnt - b_ovr), 32'(model_ovr - b_mo));
        check("ovr2_data", 32'(rx_data), 32'(model_data));
        check("ovr2_valid", 32'(rx_valid), 32'(model_valid));
        wait_ticks((TOB - 2) * OVS);
        @(negedge PCLK);
        check("to_early", 32'(to_cnt - b_to), 32'd0);
        wait_ticks(3 * OVS);
        @(negedge PCLK);
        check("to_fire", 32'(to_cnt - b_to), 32'd1);
        wait_ticks(4 * OVS);
        @(negedge PCLK);
        check("to_once", 32'(to_cnt - b_to), 32'd1);

        // reset in the middle of a data bit
        @(negedge PCLK);
        rxd = 1'b0;
        wait_ticks(OVS);
        @(negedge PCLK);
        rxd = 1'b1;
        wait_ticks(OVS);
        @(negedge PCLK);
        rxd = 1'b0;
        wait_ticks(OVS / 2);
        @(negedge PCLK);
        check("mid_busy", 32'(busy), 32'd1);
        PRESETn = 1'b0;
        rxd     = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_valid = 1'b0;
        model_data  = '0;
        check("mid_reset", 32'({rx_data, rx_valid, rx_done, parity_err, frame_err,
                                overrun_err, timeout_flag, busy}), 32'd0);
        rx_ready = 1'b1;
        idle_bits(2);
        b_done = done_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b1);
        model_complete(8'h5A);
        wait_done(b_done, "5a");
        check("5a_data", 32'(last_data), 32'(model_data));
        check("5a_errs", 32'({last_perr, last_ferr}), 32'd0);

        idle_bits(1);
        check("stray_flags", 32'(stray_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised UART receive engine that replaces the fixed baud-tick-clocked RX controller.
- Runs on PCLK with a baud_tick enable. Oversamples the serial line, detects start bits, and shifts 5..DATA_W_MAX data bits LSB first.
- Checks optional even/odd parity and 1 or 2 stop bits.
- Hands each character to the RX buffer through a valid/ready handshake, flagging parity, framing, overrun and idle-timeout events.

Parameters:
- DATA_W_MAX, 8, widest supported character; legal range 5..9.
- OVS, 16, baud_tick pulses per bit time; must be even and >= 4.
- TIMEOUT_BITS, 32, idle bit-times with an unread character before timeout_flag fires.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  reset, synchronous, active-low.
- baud_tick  in  1  single-PCLK enable pulse at OVS x baud rate.
- RXen  in  1  receiver enable.
- rxd  in  1  asynchronous serial input, idle high.
- cfg_data_bits  in  4  data bits per character; values <5 are treated as 5, values >DATA_W_MAX as DATA_W_MAX.
- cfg_parity_en  in  1  parity bit present.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_stop2  in  1  two stop bits.
- rx_data  out  DATA_W_MAX  received character, zero-extended above the configured width.
- rx_valid  out  1  rx_data holds an unread character.
- rx_ready  in  1  buffer accepts rx_data this cycle.
- rx_done  out  1  one-cycle pulse when a character completes.
- parity_err  out  1  one-cycle pulse, coincident with rx_done.
- frame_err  out  1  one-cycle pulse, coincident with rx_done.
- overrun_err  out  1  one-cycle pulse.
- timeout_flag  out  1  one-cycle pulse.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (PRESETn low at a PCLK edge): state IDLE, all counters 0, synchroniser flops 1. rx_data=0; rx_valid, rx_done, parity_err, frame_err, overrun_err, timeout_flag and busy all 0.
- Input path: rxd passes through a 2-flop synchroniser to give rxd_s. The sampler updates only when baud_tick=1.
- RXen=0: the FSM goes to IDLE on the next PCLK and the tick counter clears. rx_valid and rx_data hold until rx_ready is seen.
- States are IDLE, START, DATA, PARITY, STOP_0, STOP_1.
- IDLE:
  - A falling edge of rxd_s (previous sample 1, current 0) on a baud_tick moves to START.
  - cfg_* is latched at that point; configuration changes mid-character are ignored.
- START:
  - After OVS/2 ticks, rxd_s is sampled.
  - 0: go to DATA with tick counter 0.
  - 1: false start; return to IDLE with no pulses.
- DATA: one sample every OVS ticks, shifted in LSB first. After the latched bit count, go to PARITY if parity is enabled, else STOP_0.
- PARITY: sample once. Expected bit = XOR of the data bits XOR cfg_parity_odd. A mismatch sets an internal parity error flag; the FSM always continues to STOP_0.
- STOP_0:
  - Sample 0: frame error.
  - If cfg_stop2=1, go to STOP_1; otherwise complete.
- STOP_1: sample 0 gives a frame error; then complete.
- Complete (on the PCLK after the final sample):
  - rx_done pulses. parity_err and frame_err pulse in the same cycle if their flags are set.
  - If rx_valid=0, or rx_valid and rx_ready are both 1 in this cycle: load rx_data and set rx_valid=1.
  - Otherwise overrun_err pulses, the new character is dropped, and the old rx_data is kept.
  - The FSM returns to IDLE.
- IDLE after a frame error: a new start is accepted only after rxd_s has been seen high, because the falling-edge rule applies. A held-low break therefore yields exactly one frame_err.
- Handshake: rx_valid falls on the PCLK after rx_valid=1 and rx_ready=1, unless reloaded in that same cycle.
- Timeout counter:
  - Counts bit times (OVS ticks) while the FSM is IDLE and rx_valid=1.
  - It clears on any start detection, or when rx_valid=0.
  - When it reaches TIMEOUT_BITS, timeout_flag pulses once. It then saturates and does not re-fire until it has been cleared.
- Latency: rx_done occurs at most 2 PCLK after the baud_tick that samples the last stop bit.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP_0, STOP_1);
  - the MIN_DATA_BITS=5 constant;
  - a clamp_bits function.
- Sub-module uart_rx_bit_sampler contains the synchroniser, the falling-edge detect and the OVS tick counter with mid-bit/full-bit strobes.

Test Plan:
- OVS=16, 8N1: send 0xA5 -> after 10 bit times rx_done=1, rx_data=0xA5, rx_valid=1, no errors; rx_ready=1 -> rx_valid=0 next PCLK.
- 7 bits, even parity, stop2: send 0x35 with parity 0 -> rx_data=0x35, no errors. Repeat with the parity bit flipped -> parity_err pulse together with rx_done, rx_data=0x35.
- Low glitch of 4 ticks in IDLE -> returns to IDLE, no rx_done, busy drops within OVS/2+2 ticks.
- Stop bit driven 0, then line held low for 3 characters -> exactly one frame_err. After line high and a valid 0x11 -> rx_data=0x11.
- Two characters 0x01, 0x02 with rx_ready=0 -> second completion gives overrun_err=1, rx_data stays 0x01. Then TIMEOUT_BITS=32 idle bit times -> one timeout_flag pulse.
- PRESETn=0 for one PCLK mid-DATA -> all outputs 0, state IDLE. A following 0x5A is received correctly.
